// File: rtl/pq_pkg.sv
// Shared types and defaults for the sorted-array priority queue.
//   kv_t       : packed {key, value} entry
//   pq_state_t : FSM state of the queue device
package pq_pkg;
  localparam int KEYBITS  = 8;
  localparam int VALBITS  = 8;
  localparam int PQ_DEPTH = 16;

  typedef struct packed {
    logic [KEYBITS-1:0] key;
    logic [VALBITS-1:0] value;
  } kv_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INS  = 2'd1,
    REM  = 2'd2
  } pq_state_t;
endpackage

// File: rtl/sa_pq_rd.sv
// Sorted-array min-priority queue with an indexed read port.
// Lowest key sits at q[0]; equal keys leave in arrival order. Inserts and
// removals shift the array one slot per cycle while busy is high.
// Ports:
//   clk, rst (async, active-low)
//   enq/deq/kvi    : requests, sampled only while busy=0
//   kvo            : head entry (0 when empty)
//   full/empty/busy/count : status, combinational from registered state
//   rd_en/rd_idx   : indexed read request
//   rd_kv/rd_valid : registered read response
module sa_pq_rd
  import pq_pkg::*;
#(
  parameter  int DEPTH = PQ_DEPTH,
  parameter  int KW    = KEYBITS,
  parameter  int VW    = VALBITS,
  localparam int EW    = KW + VW,
  localparam int IW    = $clog2(DEPTH),
  localparam int CW    = IW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  logic          deq,
  input  logic [EW-1:0] kvi,
  output logic [EW-1:0] kvo,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic [CW-1:0] count,
  input  logic          rd_en,
  input  logic [IW-1:0] rd_idx,
  output logic [EW-1:0] rd_kv,
  output logic          rd_valid
);

  pq_state_t     state_r;
  pq_state_t     state_nxt_s;
  logic [EW-1:0] q_r [DEPTH];
  logic [CW-1:0] count_r;
  logic [IW-1:0] ptr_r;       // insert position in INS, shift index in REM
  logic [EW-1:0] ins_kv_r;
  logic [EW-1:0] rd_kv_r;
  logic          rd_valid_r;

  logic          full_s;
  logic          empty_s;
  logic          accept_deq_s;
  logic          accept_enq_s;
  logic          ins_done_s;
  logic          rem_done_s;
  logic          rd_hit_s;
  logic [IW-1:0] ptr_dec_s;
  logic [IW-1:0] ptr_inc_s;

  function automatic logic [KW-1:0] key_of(input logic [EW-1:0] kv);
    return kv[EW-1:VW];
  endfunction

  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == CW'(DEPTH));
  assign ptr_dec_s = ptr_r - IW'(1);
  assign ptr_inc_s = ptr_r + IW'(1);

  // Request arbitration and per-step termination conditions.
  always_comb begin
    // deq has priority; enq is only taken when no valid deq is pending.
    accept_deq_s = (state_r == IDLE) && deq && !empty_s;
    accept_enq_s = (state_r == IDLE) && enq && !full_s && !(deq && !empty_s);
    // Stop shifting once the left neighbour is <= the new key, keeping
    // equal keys in arrival order.
    ins_done_s   = (ptr_r == {IW{1'b0}}) ||
                   (key_of(q_r[ptr_dec_s]) <= key_of(ins_kv_r));
    rem_done_s   = ({1'b0, ptr_r} == (count_r - CW'(1)));
    rd_hit_s     = ({1'b0, rd_idx} < count_r) && (state_r == IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_deq_s) begin
          state_nxt_s = REM;
        end else if (accept_enq_s) begin
          state_nxt_s = INS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      INS:     state_nxt_s = ins_done_s ? IDLE : INS;
      REM:     state_nxt_s = rem_done_s ? IDLE : REM;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs and status flags.
  always_comb begin
    busy  = (state_r != IDLE);
    full  = full_s;
    empty = empty_s;
    count = count_r;
    kvo   = empty_s ? {EW{1'b0}} : q_r[0];
  end

  // Shift array, occupancy and step pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_r[i] <= {EW{1'b0}};
      end
      count_r  <= {CW{1'b0}};
      ptr_r    <= {IW{1'b0}};
      ins_kv_r <= {EW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_deq_s) begin
            ptr_r <= {IW{1'b0}};
          end else if (accept_enq_s) begin
            ins_kv_r <= kvi;
            // Not full here, so count fits in the index width.
            ptr_r    <= count_r[IW-1:0];
          end
        end
        INS: begin
          if (ins_done_s) begin
            q_r[ptr_r] <= ins_kv_r;
            count_r    <= count_r + CW'(1);
          end else begin
            q_r[ptr_r] <= q_r[ptr_dec_s];
            ptr_r      <= ptr_dec_s;
          end
        end
        REM: begin
          if (rem_done_s) begin
            q_r[ptr_r] <= {EW{1'b0}};
            count_r    <= count_r - CW'(1);
          end else begin
            q_r[ptr_r] <= q_r[ptr_inc_s];
            ptr_r      <= ptr_inc_s;
          end
        end
        default: begin
          ptr_r <= {IW{1'b0}};
        end
      endcase
    end
  end

  // Indexed read port; only answers from a stable (idle) array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_kv_r    <= {EW{1'b0}};
      rd_valid_r <= 1'b0;
    end else if (rd_en) begin
      if (rd_hit_s) begin
        rd_kv_r    <= q_r[rd_idx];
        rd_valid_r <= 1'b1;
      end else begin
        rd_kv_r    <= {EW{1'b0}};
        rd_valid_r <= 1'b0;
      end
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

  assign rd_kv    = rd_kv_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_sa_pq_rd.sv
module tb_sa_pq_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enq = 1'b0;
  logic        deq = 1'b0;
  logic [15:0] kvi = 16'h0000;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_idx = 4'd0;
  logic [15:0] kvo;
  logic        full;
  logic        empty;
  logic        busy;
  logic [4:0]  count;
  logic [15:0] rd_kv;
  logic        rd_valid;

  sa_pq_rd dut (
    .clk(clk), .rst(rst), .enq(enq), .deq(deq), .kvi(kvi), .kvo(kvo),
    .full(full), .empty(empty), .busy(busy), .count(count),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_kv(rd_kv), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] kvo_acc;
  logic [15:0] rd_kv_seen;
  logic        rd_valid_seen;
  int          busy_seen;
  logic [15:0] model_q[$];

  typedef struct {
    logic        e;
    logic        d;
    logic [15:0] kv;
    int          exp_busy;
    logic [15:0] exp_acc;
    logic [15:0] exp_kvo;
    int          exp_cnt;
  } vec_t;

  vec_t        vecs[13];
  logic [15:0] rd_exp_kv[5];
  logic        rd_exp_v[5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request cycle, then wait (bounded) for busy to drop.
  task automatic op(input logic e, input logic d, input logic [15:0] kv,
                    input logic r, input logic [3:0] ri);
    enq = e; deq = d; kvi = kv; rd_en = r; rd_idx = ri;
    kvo_acc = kvo;
    tick;
    enq = 1'b0; deq = 1'b0; rd_en = 1'b0;
    rd_kv_seen = rd_kv;
    rd_valid_seen = rd_valid;
    busy_seen = 0;
    while (busy && busy_seen < 64) begin
      busy_seen++;
      tick;
    end
    chk("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic        e, d, r;
    logic [3:0]  ri;
    logic [15:0] kv, exp_rd;
    logic        exp_rv;
    int          exp_busy, pos;
    logic [15:0] exp_acc;

    vecs[0]  = '{1'b1, 1'b0, 16'h05A1, 1, 16'h0000, 16'h05A1, 1};
    vecs[1]  = '{1'b1, 1'b0, 16'h03B2, 2, 16'h05A1, 16'h03B2, 2};
    vecs[2]  = '{1'b1, 1'b0, 16'h07C3, 1, 16'h03B2, 16'h03B2, 3};
    vecs[3]  = '{1'b1, 1'b0, 16'h03D4, 3, 16'h03B2, 16'h03B2, 4};
    vecs[4]  = '{1'b1, 1'b0, 16'h0100, 5, 16'h03B2, 16'h0100, 5};
    vecs[5]  = '{1'b0, 1'b1, 16'h0000, 5, 16'h0100, 16'h03B2, 4};
    vecs[6]  = '{1'b0, 1'b1, 16'h0000, 4, 16'h03B2, 16'h03D4, 3};
    vecs[7]  = '{1'b0, 1'b1, 16'h0000, 3, 16'h03D4, 16'h05A1, 2};
    vecs[8]  = '{1'b0, 1'b1, 16'h0000, 2, 16'h05A1, 16'h07C3, 1};
    vecs[9]  = '{1'b0, 1'b1, 16'h0000, 1, 16'h07C3, 16'h0000, 0};
    vecs[10] = '{1'b0, 1'b1, 16'h0000, 0, 16'h0000, 16'h0000, 0};
    vecs[11] = '{1'b1, 1'b1, 16'h0AEE, 1, 16'h0000, 16'h0AEE, 1};
    vecs[12] = '{1'b0, 1'b1, 16'h0000, 1, 16'h0AEE, 16'h0000, 0};
    rd_exp_kv = '{16'h03B2, 16'h03D4, 16'h05A1, 16'h07C3, 16'h0000};
    rd_exp_v  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    tick; tick;
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_kvo", {16'd0, kvo}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    rst = 1'b1;
    tick;

    // Half fill, then reset in the middle of a long insert
    for (int i = 0; i < 8; i++) begin
      b = 8'(i);
      op(1'b1, 1'b0, {8'h20 + b, b}, 1'b0, 4'd0);
    end
    chk("half_count", {27'd0, count}, 32'd8);
    enq = 1'b1; kvi = 16'h0055;
    tick;
    enq = 1'b0;
    tick;
    chk("mid_ins_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_count", {27'd0, count}, 32'd0);
    tick;
    chk("midrst_count", {27'd0, count}, 32'd0);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_kvo", {16'd0, kvo}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    rst = 1'b1;
    tick;
    op(1'b0, 1'b0, 16'h0000, 1'b1, 4'd0);
    chk("postrst_rd_valid", {31'd0, rd_valid_seen}, 32'd0);
    chk("postrst_rd_kv", {16'd0, rd_kv_seen}, 32'd0);

    // Directed fill / read / drain table
    for (int i = 0; i < 13; i++) begin
      if (i == 4) begin
        for (int j = 0; j < 5; j++) begin
          op(1'b0, 1'b0, 16'h0000, 1'b1, 4'(j));
          chk($sformatf("read%0d_kv", j), {16'd0, rd_kv_seen}, {16'd0, rd_exp_kv[j]});
          chk($sformatf("read%0d_valid", j), {31'd0, rd_valid_seen}, {31'd0, rd_exp_v[j]});
        end
      end
      op(vecs[i].e, vecs[i].d, vecs[i].kv, 1'b0, 4'd0);
      chk($sformatf("vec%0d_busy", i), busy_seen, vecs[i].exp_busy);
      chk($sformatf("vec%0d_acc_kvo", i), {16'd0, kvo_acc}, {16'd0, vecs[i].exp_acc});
      chk($sformatf("vec%0d_kvo", i), {16'd0, kvo}, {16'd0, vecs[i].exp_kvo});
      chk($sformatf("vec%0d_count", i), {27'd0, count}, vecs[i].exp_cnt);
    end
    chk("drained_empty", {31'd0, empty}, 32'd1);

    // Full boundary
    for (int i = 0; i < 16; i++) begin
      b = 8'(i);
      op(1'b1, 1'b0, {8'h10 + b, b}, 1'b0, 4'd0);
    end
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_count", {27'd0, count}, 32'd16);
    op(1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
    chk("full_enq_busy", busy_seen, 0);
    chk("full_enq_count", {27'd0, count}, 32'd16);
    chk("full_enq_kvo", {16'd0, kvo}, 32'h1000);
    op(1'b1, 1'b1, 16'h0000, 1'b0, 4'd0);
    chk("full_both_busy", busy_seen, 16);
    chk("full_both_count", {27'd0, count}, 32'd15);
    chk("full_both_full", {31'd0, full}, 32'd0);
    chk("full_both_kvo", {16'd0, kvo}, 32'h1101);
    for (int i = 0; i < 15; i++) op(1'b0, 1'b1, 16'h0000, 1'b0, 4'd0);
    chk("full_drain_empty", {31'd0, empty}, 32'd1);

    // Requests pulsed while busy
    op(1'b1, 1'b0, 16'h0AEE, 1'b0, 4'd0);
    enq = 1'b1; kvi = 16'h0511;
    tick;
    enq = 1'b1; deq = 1'b1; kvi = 16'h0122; rd_en = 1'b1; rd_idx = 4'd0;
    tick;
    enq = 1'b0; deq = 1'b0; rd_en = 1'b0;
    chk("busy_pulse_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("busy_pulse_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("busy_pulse_done", {31'd0, busy}, 32'd0);
    chk("busy_pulse_count", {27'd0, count}, 32'd2);
    chk("busy_pulse_kvo", {16'd0, kvo}, 32'h0511);

    // Randomized traffic against a queue model
    rst = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    model_q.delete();
    for (int n = 0; n < 500; n++) begin
      e  = ($urandom_range(0, 99) < 60);
      d  = ($urandom_range(0, 99) < 45);
      r  = 1'($urandom_range(0, 1));
      ri = 4'($urandom_range(0, 15));
      kv = {4'h0, 4'($urandom_range(0, 15)), 8'($urandom)};
      if (int'(ri) < model_q.size()) begin
        exp_rd = model_q[ri]; exp_rv = 1'b1;
      end else begin
        exp_rd = 16'h0000; exp_rv = 1'b0;
      end
      exp_acc = (model_q.size() > 0) ? model_q[0] : 16'h0000;
      if (d && model_q.size() > 0) begin
        exp_busy = model_q.size();
        void'(model_q.pop_front());
      end else if (e && model_q.size() < 16) begin
        pos = model_q.size();
        for (int j = 0; j < model_q.size(); j++) begin
          if (model_q[j][15:8] > kv[15:8]) begin
            pos = j;
            break;
          end
        end
        exp_busy = model_q.size() - pos + 1;
        model_q.insert(pos, kv);
      end else begin
        exp_busy = 0;
      end
      op(e, d, kv, r, ri);
      chk($sformatf("rnd%0d_busy", n), busy_seen, exp_busy);
      chk($sformatf("rnd%0d_acc_kvo", n), {16'd0, kvo_acc}, {16'd0, exp_acc});
      chk($sformatf("rnd%0d_count", n), {27'd0, count}, model_q.size());
      chk($sformatf("rnd%0d_kvo", n), {16'd0, kvo},
          {16'd0, (model_q.size() > 0) ? model_q[0] : 16'h0000});
      if (r) begin
        chk($sformatf("rnd%0d_rd_valid", n), {31'd0, rd_valid_seen}, {31'd0, exp_rv});
        chk($sformatf("rnd%0d_rd_kv", n), {16'd0, rd_kv_seen}, {16'd0, exp_rd});
      end else begin
        chk($sformatf("rnd%0d_rd_idle", n), {31'd0, rd_valid_seen}, 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_pq_rd.md
Name: sa_pq_rd

Overview:
- Sorted-array min-priority queue. Acts as the device (responder) end of the PQ read-capable client/device protocol; the automaton client drives enq/deq and inspects queue contents for display.
- Entries are kv_t: 8-bit key, 8-bit value. The lowest key is at the head; equal keys leave in FIFO order.
- Insert and remove are multi-cycle shift operations, signalled by busy.
- An indexed read port lets the client scan the contents without dequeuing.

Parameters:
- DEPTH, 16, number of entries (power of 2, ≥2).
- KW, 8, key width.
- VW, 8, value width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-low.
- enq  in  1  enqueue request; sampled only when busy=0.
- deq  in  1  dequeue request; sampled only when busy=0.
- kvi  in  16  key/value to enqueue; {key[15:8], value[7:0]}.
- kvo  out  16  head entry (q[0]); 0 when empty.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- busy  out  1  insert or remove in progress.
- count  out  $clog2(DEPTH)+1  current occupancy.
- rd_en  in  1  indexed read request.
- rd_idx  in  $clog2(DEPTH)  read index, 0 = head.
- rd_kv  out  16  registered read data.
- rd_valid  out  1  registered: read hit a valid entry.

Behaviour:
- Reset (rst=0, async): all q[i]=0, count=0, state=IDLE, rd_kv=0, rd_valid=0. Outputs: kvo=0, empty=1, full=0, busy=0.
- kvo, full, empty, count are combinational from registered state.
- busy = (state != IDLE).
- FSM states are IDLE, INS and REM.
- IDLE, request arbitration:
  - deq && !empty → latch idx=0, go REM. The kvo value in the accept cycle is the dequeued entry.
  - else enq && !full → latch ins_kv=kvi and pos=count, go INS.
  - deq && enq && !empty: deq wins; enq is dropped and the client re-issues.
  - deq && enq && empty: enq is accepted.
  - enq while full, or deq while empty: ignored, no state change, busy stays 0.
- INS, one step per cycle:
  - if pos==0 or q[pos-1].key ≤ ins_kv.key: write q[pos]=ins_kv, count+=1, go IDLE.
  - else: q[pos]=q[pos-1], pos-=1.
  - The ≤ comparison gives FIFO order among equal keys.
  - Latency: busy is high for (number of stored keys > new key) + 1 cycles.
- REM, one step per cycle:
  - if idx==count-1: q[idx]=0, count-=1, go IDLE.
  - else: q[idx]=q[idx+1], idx+=1.
  - Busy is high for count cycles, using the count at accept.
- enq/deq asserted while busy=1 are ignored; the client holds its request until it is accepted.
- Read port:
  - Next edge after rd_en: rd_kv = q[rd_idx] and rd_valid=1, if rd_idx<count and busy=0.
  - Otherwise rd_kv=0 and rd_valid=0.
  - rd_en low: rd_valid=0, rd_kv holds.
  - Reads never alter queue state and may coincide with an enq/deq accept; they return the pre-accept contents.
- Key comparison is unsigned KW-bit; the value field is never compared.
- Reset asserted mid-INS/REM: immediate abort, all state cleared as above; no partial entry survives.
- Wrap-around does not occur: count saturates at DEPTH by construction (full blocks enq).

Decomposition:
- pq_pkg holds: kv_t (packed struct key[KW-1:0], value[VW-1:0]), KEYBITS/VALBITS constants, PQ_DEPTH default, and the pq_state_t enum {IDLE, INS, REM}.
- Single module; no sub-module is natural, since the shift array and FSM are tightly coupled.
- The block is port-compatible with the dev modport of the read-capable PQ interface, so it drops into the top level in place of the existing device.

Test Plan:
- Reset with queue half full, asserted mid-INS → next cycle count=0, empty=1, kvo=0x0000, busy=0, rd_valid=0.
- Enqueue 0x05A1, 0x03B2, 0x07C3, 0x03D4, each after busy falls → kvo=0x03B2. Reads of idx 0..3 return 0x03B2, 0x03D4, 0x05A1, 0x07C3 with rd_valid=1. Read of idx 4 gives rd_valid=0, rd_kv=0.
- Busy-duration check on the previous fill:
  - enq 0x03D4 has 2 larger keys → busy high for 3 cycles.
  - enq 0x0100 into 4 entries → busy high for 5 cycles, kvo=0x0100.
- Deq from count=4 → kvo=0x03B2 in the accept cycle, busy high 4 cycles, then count=3 and kvo=0x03D4. Deq repeated to empty, then deq once more → ignored, busy=0, empty=1.
- Fill 16 entries, keys 0x10..0x1F → full=1. enq 0x0000 is ignored: count=16, kvo=0x1000. Simultaneous enq+deq → deq wins, count=15, full=0.
- enq/deq/rd_en pulsed during busy → no extra state change, rd_valid=0.
- Simultaneous enq+deq with empty=1 and kvi=0x0AEE → count=1, kvo=0x0AEE.
